signed_accum_n: RTL and testbench
=================================

Name: signed_accum_n

Overview:
- Parametrised successor to the 4-bit signed adder with overflow flag.
- Accumulates a programmable-length burst of signed two's-complement samples into a wider accumulator, with optional per-sample subtract and a sticky overflow flag.
- Sits between a sample producer and a consumer, using valid/ready handshakes on both sides.
- Emits one result per burst.

Parameters:
- WIDTH, 4, sample width in bits (signed two's complement); must be >= 2.
- ACC_W, 8, accumulator and result width; must be > WIDTH.
- N_MAX, 16, maximum burst length. Derived: CNT_W = $clog2(N_MAX+1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; returns to IDLE.
- len  input  CNT_W  burst length; sampled with the first sample of a burst.
- in_valid  input  1  sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  WIDTH  signed sample.
- in_sub  input  1  1 = subtract this sample, 0 = add it.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  signed burst result.
- out_ovf  output  1  sticky overflow for this burst.
- busy  output  1  high in ACC or HOLD.

Behaviour:
- Interface: clock and reset are fixed as one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, in_ready=0 while reset is asserted, busy=0. in_ready rises in the first cycle after reset deassertion.
- Sample accept: a sample is accepted on a rising edge where in_valid && in_ready.
- Operand: in_data sign-extended to ACC_W, then two's-complement negated when in_sub=1. Negating -2^(WIDTH-1) is exact because ACC_W > WIDTH.
- Sum: next = acc + op, computed at ACC_W bits.
- Overflow: acc and op have the same sign and next has a different sign. On overflow, ovf is set and stays set until the burst is consumed, clear, or reset.
- FSM state IDLE:
  - in_ready=1.
  - On accept: lat_len = (len==0 ? 1 : min(len, N_MAX)); acc = op (the first sample never overflows); cnt=1; ovf=0.
  - Go to HOLD if lat_len==1, else go to ACC.
- FSM state ACC:
  - in_ready=1.
  - On accept: acc=next, cnt=cnt+1.
  - When the incremented cnt == lat_len, go to HOLD.
  - len changes during ACC are ignored.
- FSM state HOLD:
  - in_ready=0, out_valid=1; out_sum=acc and out_ovf=ovf, both stable.
  - On out_ready, go to IDLE at the next edge.
  - There is no same-cycle acceptance of a new burst (one bubble cycle).
- Latency: out_valid asserts on the cycle after the last sample is accepted.
- Backpressure: HOLD persists indefinitely while out_ready=0. Producer stalls (in_valid low) in ACC are allowed with no timeout.
- clear:
  - Synchronous; has priority over accept and emit.
  - From any state: go to IDLE, acc=0, cnt=0, ovf=0, out_valid=0 next cycle. Any sample offered in the same cycle is dropped.
  - An in-flight result in HOLD is discarded.
- Reset mid-burst: everything is abandoned immediately; no partial result is emitted.
- Outputs out_sum and out_ovf hold their last values in IDLE (acc is not zeroed on emit); consumers qualify them with out_valid.

Optional Feature:
- Macro: SIGNED_ACCUM_N_SAT_EN.
- Defined: on overflow, acc saturates to +2^(ACC_W-1)-1 (if op was non-negative) or -2^(ACC_W-1) (if op was negative). Accumulation continues from the saturated value; ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W; ovf is set.

Decomposition:
- Package signed_accum_pkg:
  - state enum typedef (IDLE, ACC, HOLD);
  - functions sat_max(ACC_W) and sat_min(ACC_W);
  - function add_ovf(a, b, s) returning the overflow bit.
- Sub-module signed_addsub_ovf (combinational): sign-extend, conditional negate, add, overflow detect, optional saturate. Parametrised by WIDTH/ACC_W and reused by the top-level FSM.

Test Plan (WIDTH=4, ACC_W=6, N_MAX=8 unless noted):
- Basic: len=3; samples 7, 1, -8, all in_sub=0 -> out_valid one cycle after third accept; out_sum=0, out_ovf=0.
- Subtract: len=2; sample -8 with in_sub=1, then -3 with in_sub=0 -> out_sum=5, out_ovf=0.
- Overflow: len=5; sample 7 five times:
  - without macro -> out_sum=-29, out_ovf=1;
  - with SIGNED_ACCUM_N_SAT_EN -> out_sum=31, out_ovf=1.
- Backpressure: len=1, sample -5, out_ready low for 3 cycles -> out_sum=-5 stable, in_ready=0 throughout; IDLE reached one cycle after out_ready=1.
- Edge length: len=0, sample 4 -> treated as a length-1 burst, out_sum=4. Next burst with len=8 of eight -4 samples -> out_sum=-32, out_ovf=0.
- Abort:
  - clear pulsed after 2 of 4 samples -> no out_valid; the next burst of len=1, sample 3 gives out_sum=3, out_ovf=0.
  - Repeat with rst_n pulsed low mid-burst -> identical recovery.

Source files
------------

// File: rtl/signed_accum_pkg.sv
// rtl/signed_accum_pkg.sv - shared types and arithmetic helpers for signed_accum_n
package signed_accum_pkg;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  // Bit patterns of the signed extremes of a w-bit value, zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // Arguments are the sign bits of both addends and of the sum.
  function automatic logic add_ovf(input logic a, input logic b, input logic s);
    return (a == b) && (s != a);
  endfunction

endpackage

// File: rtl/signed_addsub_ovf.sv
// rtl/signed_addsub_ovf.sv - sign-extend, optional negate, add with overflow; saturates under SIGNED_ACCUM_N_SAT_EN
module signed_addsub_ovf
  import signed_accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [WIDTH-1:0] data,
  input  logic             sub,
  output logic [ACC_W-1:0] op,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] raw;

  // ACC_W > WIDTH, so negating the most negative sample cannot overflow here.
  assign ext = {{(ACC_W-WIDTH){data[WIDTH-1]}}, data};
  assign op  = sub ? -ext : ext;
  assign raw = acc + op;
  assign ovf = add_ovf(acc[ACC_W-1], op[ACC_W-1], raw[ACC_W-1]);

`ifdef SIGNED_ACCUM_N_SAT_EN
  localparam logic [ACC_W-1:0] SMAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] SMIN = ACC_W'(sat_min(ACC_W));
  assign sum = ovf ? (op[ACC_W-1] ? SMIN : SMAX) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/signed_accum_n.sv
// rtl/signed_accum_n.sv - burst accumulator of signed samples with sticky overflow; SIGNED_ACCUM_N_SAT_EN selects saturation
module signed_accum_n
  import signed_accum_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int N_MAX = 16,
  localparam int CNT_W = $clog2(N_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_len;
  logic [CNT_W-1:0] len_eff;
  logic             ovf;
  logic [ACC_W-1:0] op;
  logic [ACC_W-1:0] sum_nxt;
  logic             ovf_nxt;
  logic             accept;

  signed_addsub_ovf #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_addsub (
    .acc  (acc),
    .data (in_data),
    .sub  (in_sub),
    .op   (op),
    .sum  (sum_nxt),
    .ovf  (ovf_nxt)
  );

  always_comb begin
    len_eff = len;
    if (len == '0)
      len_eff = CNT_W'(1);
    else if (len > CNT_W'(N_MAX))
      len_eff = CNT_W'(N_MAX);
  end

  assign accept  = in_valid && in_ready;
  assign out_sum = acc;
  assign out_ovf = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      lat_len   <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            // The first sample loads the accumulator, so it can never overflow.
            acc     <= op;
            cnt     <= CNT_W'(1);
            ovf     <= 1'b0;
            lat_len <= len_eff;
            busy    <= 1'b1;
            if (len_eff == CNT_W'(1)) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc <= sum_nxt;
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf | ovf_nxt;
            if (cnt + CNT_W'(1) == lat_len) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_accum_n.sv
// tb/tb_signed_accum_n.sv - directed bench for signed_accum_n with a reference model
module tb_signed_accum_n;

  localparam int WIDTH = 4;
  localparam int ACC_W = 6;
  localparam int N_MAX = 8;
  localparam int CNT_W = $clog2(N_MAX + 1);
  localparam int MAXV  = 2 ** (ACC_W - 1) - 1;
  localparam int MINV  = -(2 ** (ACC_W - 1));

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain integer arithmetic on the burst.
  bit m_active = 0;
  int m_len, m_cnt, m_acc;
  bit m_ovf;
  int exp_sum_q[$];
  bit exp_ovf_q[$];

  signed_accum_n #(.WIDTH(WIDTH), .ACC_W(ACC_W), .N_MAX(N_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_accept(input int d, input bit sub, input int l);
    int op, nx;
    op = sub ? -d : d;
    if (!m_active) begin
      m_active = 1;
      m_len = (l == 0) ? 1 : ((l > N_MAX) ? N_MAX : l);
      m_cnt = 1;
      m_acc = op;
      m_ovf = 0;
    end else begin
      nx = m_acc + op;
      if (nx > MAXV || nx < MINV) begin
        m_ovf = 1;
`ifdef SIGNED_ACCUM_N_SAT_EN
        nx = (op >= 0) ? MAXV : MINV;
`else
        nx = (nx > MAXV) ? nx - 2 ** ACC_W : nx + 2 ** ACC_W;
`endif
      end
      m_acc = nx;
      m_cnt++;
    end
    if (m_cnt == m_len) begin
      m_active = 0;
      exp_sum_q.push_back(m_acc);
      exp_ovf_q.push_back(m_ovf);
    end
  endtask

  // Compare process: whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_sum_q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        check("out_sum", $signed(out_sum), exp_sum_q[0]);
        check("out_ovf", int'(out_ovf), int'(exp_ovf_q[0]));
      end
    end
  end

  task automatic send(input int d, input bit sub, input int l);
    bit ir;
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d[WIDTH-1:0];
    in_sub   = sub;
    len      = l[CNT_W-1:0];
    n = 0;
    do begin
      ir = in_ready;
      @(posedge clk);
      n++;
    end while (!ir && n < 20);
    #1 in_valid = 1'b0;
    if (!ir) check("accept_timeout", 0, 1);
    else model_accept(d, sub, l);
  endtask

  task automatic finish_burst(input string name, input int lit_sum, input bit lit_ovf, input int hold);
    int n;
    if (exp_sum_q.size() == 0) begin
      check({name, "_model_empty"}, 0, 1);
      return;
    end
    check({name, "_model_sum"}, exp_sum_q[0], lit_sum);
    check({name, "_model_ovf"}, int'(exp_ovf_q[0]), int'(lit_ovf));
    @(negedge clk);
    check({name, "_latency"}, int'(out_valid), 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < hold; i++) begin
      check({name, "_hold_in_ready"}, int'(in_ready), 0);
      @(negedge clk);
      check({name, "_hold_valid"}, int'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    void'(exp_sum_q.pop_front());
    void'(exp_ovf_q.pop_front());
    @(negedge clk);
    check({name, "_idle_busy"}, int'(busy), 0);
    check({name, "_idle_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
`ifdef SIGNED_ACCUM_N_SAT_EN
    localparam int OVF_SUM = 31;
`else
    localparam int OVF_SUM = -29;
`endif
    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_sum", int'(out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);

    // Basic
    send(7, 0, 3); send(1, 0, 3); send(-8, 0, 3);
    finish_burst("basic", 0, 0, 0);

    // Subtract, with a producer stall between samples
    send(-8, 1, 2);
    repeat (3) @(negedge clk);
    check("stall_busy", int'(busy), 1);
    send(-3, 0, 2);
    finish_burst("subtract", 5, 0, 0);

    // Overflow
    for (int i = 0; i < 5; i++) send(7, 0, 5);
    finish_burst("overflow", OVF_SUM, 1, 0);

    // Backpressure
    send(-5, 0, 1);
    finish_burst("backpressure", -5, 0, 3);

    // Edge lengths
    send(4, 0, 0);
    finish_burst("len0", 4, 0, 0);
    for (int i = 0; i < 8; i++) send(-4, 0, 8);
    finish_burst("len8", -32, 0, 0);

    // Abort by clear, with a sample offered in the same cycle
    send(5, 0, 4); send(6, 0, 4);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 4'd2;
    @(posedge clk);
    #1 clear = 1'b0; in_valid = 1'b0;
    m_active = 0;
    @(negedge clk);
    check("clear_busy", int'(busy), 0);
    check("clear_out_valid", int'(out_valid), 0);
    send(3, 0, 1);
    finish_burst("after_clear", 3, 0, 0);

    // Abort by reset
    send(5, 0, 4); send(6, 0, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_busy", int'(busy), 0);
    m_active = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(3, 0, 1);
    finish_burst("after_reset", 3, 0, 0);

    repeat (3) @(negedge clk);
    check("leftover_results", exp_sum_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
